mem_access_router: RTL and testbench
====================================

Name: mem_access_router

Overview:
- Next-generation memory/IO access controller for the 3-stage RISC-V core. It sits between the core's fetch/memory stage and the BIOS, instruction and data memories and the IO bus.
- Decodes the PC and data-address region tags into fetch/load selects and per-memory write enables.
- Generates byte lanes from access size and address.
- Delays load selects to match synchronous memory read latency.
- Runs multi-cycle IO accesses through a req/ack handshake with stall and timeout.

Parameters:
- ADDR_W, 32, address width; tag = addr[ADDR_W-1 -: 4].
- READ_LAT, 1, memory read latency in cycles (1..4); load selects are delayed by this many cycles.
- IO_TIMEOUT, 255, maximum IO_WAIT cycles before a fault (1..65535).
- IMEM_WR_NEEDS_BIOS, 1, when 1, instruction-memory writes are allowed only while the PC tag has bit 2 set (executing from BIOS).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- pc  in  ADDR_W  fetch PC.
- data_addr  in  ADDR_W  load/store address.
- mem_req  in  1  memory-stage access valid this cycle.
- mem_we  in  1  1=store, 0=load.
- mem_size  in  2  00=byte, 01=half, 10=word, 11=illegal.
- iwea  out  4  instruction-memory byte write enables.
- dwea  out  4  data-memory byte write enables.
- iload_sel  out  1  0=instruction memory, 1=BIOS fetch data; delayed by READ_LAT.
- dload_sel  out  2  00=data memory, 01=BIOS, 10=IO read data; delayed by READ_LAT.
- io_req  out  1  IO request, held until ack.
- io_we  out  1  IO write qualifier, valid with io_req.
- io_be  out  4  IO byte enables, valid with io_req.
- io_ack  in  1  IO completion.
- stall  out  1  holds the pipeline.
- fault  out  1  one-cycle pulse on misaligned, illegal, unmapped or timed-out access.
- fault_code  out  2  01=misaligned/illegal size, 10=unmapped, 11=IO timeout; held until the next fault.

Behaviour:
- Reset (rst_n=0, async): state=IDLE. iwea, dwea, io_req, io_we, io_be, stall, fault, fault_code all 0. Load-select pipelines cleared to 0. Timeout counter 0.
- Byte lanes (combinational), off=data_addr[1:0]:
  - byte: be = 1<<off.
  - half: be = 0011<<off; off must be 0 or 2.
  - word: be = 1111; off must be 0.
  - Misaligned or size 11: be=0 and the access is faulted.
- Fetch decode on pc tag (registered into a READ_LAT-deep shift register):
  - 0001 -> iload_sel=0.
  - 0100 -> iload_sel=1.
  - Other tags -> 0.
- Data decode on data_addr tag, combinational write enables, qualified by mem_req & mem_we & aligned:
  - 0001: dwea=be.
  - 0010: iwea=be if the PC-tag condition holds (or IMEM_WR_NEEDS_BIOS=0), else 0.
  - 0011: dwea=be; iwea as for 0010.
  - 0100: BIOS is read-only; store writes nothing and raises no fault.
  - 1000: IO.
  - Any other tag with mem_req: unmapped fault; no enables.
- Loads: the dload_sel code (0001/0011 -> 00, 0100 -> 01, 1000 -> 10) enters a READ_LAT-deep shift register. The output is the entry from READ_LAT cycles earlier. Non-load cycles shift in 00.
- IO FSM:
  - IDLE: mem_req with tag 1000 and aligned -> latch io_we/io_be; next cycle io_req=1, state=IO_WAIT. stall=1 combinationally in the request cycle and through IO_WAIT.
  - IO_WAIT: counter increments each cycle.
    - io_ack=1 -> io_req=0 and state=IDLE next cycle. stall drops in the ack cycle (combinational on io_ack). dload_sel path sees code 10 for loads.
    - Counter reaches IO_TIMEOUT with no ack -> fault pulse, fault_code=11, io_req=0, state=IDLE, stall released.
  - io_ack outside IO_WAIT is ignored.
  - Ack and timeout in the same cycle: ack wins, no fault.
  - New inputs are ignored while in IO_WAIT, since the core is stalled.
- fault is registered: it pulses one cycle after the offending access. A faulted access writes nothing and does not start IO.
- Async reset in IO_WAIT drops io_req immediately.

Test Plan:
- Store word to 0x1000_0010, size=10 -> dwea=1111, iwea=0000, no stall, no fault.
- PC=0x4000_0000, store half to 0x3000_0006 -> dwea=1100, iwea=1100. Same store with PC=0x1000_0000 -> iwea=0000, dwea=1100.
- Store byte to 0x1000_0003 -> dwea=1000. Store word to 0x1000_0002 -> dwea=0, fault pulse next cycle, fault_code=01.
- READ_LAT=2, fetch at PC 0x4000_0000 then 0x1000_0000 -> iload_sel=1 two cycles later, then 0. Load from 0x4000_0004 -> dload_sel=01 exactly two cycles later.
- IO load from 0x8000_0000, io_ack after 5 cycles -> io_req high for 5 cycles, io_we=0, stall high until the ack cycle, dload_sel=10 READ_LAT after the ack.
- IO store with IO_TIMEOUT=8 and no ack -> io_req drops after 8 wait cycles, fault=1 for one cycle, fault_code=11, stall released. Assert rst_n=0 mid-wait on a second run -> io_req=0 and stall=0 immediately.

Source files
------------

// File: rtl/mem_access_router_if.sv
// mem_access_router_if: core-side access bus, memory enables/selects and IO handshake
interface mem_access_router_if #(parameter int ADDR_W = 32);
  logic [ADDR_W-1:0] pc, data_addr;
  logic mem_req, mem_we;
  logic [1:0] mem_size;
  logic [3:0] iwea, dwea;
  logic iload_sel;
  logic [1:0] dload_sel;
  logic io_req, io_we;
  logic [3:0] io_be;
  logic io_ack, stall, fault;
  logic [1:0] fault_code;
  modport slave (
    input pc, data_addr, mem_req, mem_we, mem_size, io_ack,
    output iwea, dwea, iload_sel, dload_sel, io_req, io_we, io_be, stall, fault, fault_code
  );
  modport master (
    output pc, data_addr, mem_req, mem_we, mem_size, io_ack,
    input iwea, dwea, iload_sel, dload_sel, io_req, io_we, io_be, stall, fault, fault_code
  );
endinterface

// File: rtl/mem_access_router.sv
// mem_access_router: region decode, byte lanes, load-select delay and IO handshake for the core
module mem_access_router #(
  parameter int ADDR_W = 32,
  parameter int READ_LAT = 1,
  parameter int IO_TIMEOUT = 255,
  parameter int IMEM_WR_NEEDS_BIOS = 1
) (
  input logic clk,
  input logic rst_n,
  mem_access_router_if.slave bus
);
  typedef enum logic {IDLE, IO_WAIT} state_t;
  localparam logic [15:0] tmo_last = 16'(IO_TIMEOUT - 1);
  state_t state, state_nx;
  logic [3:0] ptag, dtag, be;
  logic [1:0] off, din;
  logic aligned, mapped, act, st, bios_ok, start, ack, tmo, flt;
  logic [15:0] cnt;
  logic [READ_LAT-1:0] ip;
  logic [1:0] dp [READ_LAT];
  logic unused_addr_bits;
  assign ptag = bus.pc[ADDR_W-1 -: 4];
  assign dtag = bus.data_addr[ADDR_W-1 -: 4];
  assign off = bus.data_addr[1:0];
  assign unused_addr_bits = ^{bus.pc[ADDR_W-5:0], bus.data_addr[ADDR_W-5:2]};
  assign bus.iload_sel = ip[READ_LAT-1];
  assign bus.dload_sel = dp[READ_LAT-1];
  always_comb begin
    aligned = bus.mem_size == 2'b00 || (bus.mem_size == 2'b01 && !off[0]) ||
              (bus.mem_size == 2'b10 && off == 2'b00);
    be = !aligned ? 4'b0000 : bus.mem_size == 2'b00 ? 4'b0001 << off :
         bus.mem_size == 2'b01 ? 4'b0011 << off : 4'b1111;
    mapped = dtag inside {4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b1000};
    bios_ok = IMEM_WR_NEEDS_BIOS == 0 || ptag[2];
    act = bus.mem_req && rst_n && state == IDLE;
    st = act && bus.mem_we && aligned && mapped;
    bus.dwea = st && (dtag == 4'b0001 || dtag == 4'b0011) ? be : 4'b0000;
    bus.iwea = st && bios_ok && (dtag == 4'b0010 || dtag == 4'b0011) ? be : 4'b0000;
    start = act && aligned && dtag == 4'b1000;
    ack = state == IO_WAIT && bus.io_ack;
    tmo = state == IO_WAIT && !bus.io_ack && cnt == tmo_last;
    flt = act && !(aligned && mapped);
    bus.stall = start || (state == IO_WAIT && !bus.io_ack);
    din = ack && !bus.io_we ? 2'b10 :
          act && !bus.mem_we && aligned && dtag == 4'b0100 ? 2'b01 : 2'b00;
    state_nx = start ? IO_WAIT : (ack || tmo) ? IDLE : state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      bus.io_req <= 1'b0;
      bus.io_we <= 1'b0;
      bus.io_be <= 4'b0000;
      bus.fault <= 1'b0;
      bus.fault_code <= 2'b00;
      cnt <= '0;
      ip <= '0;
      for (int i = 0; i < READ_LAT; i++) dp[i] <= 2'b00;
    end else begin
      state <= state_nx;
      bus.io_req <= state_nx == IO_WAIT;
      if (start) begin
        bus.io_we <= bus.mem_we;
        bus.io_be <= be;
      end
      cnt <= state == IO_WAIT ? cnt + 16'd1 : 16'd0;
      bus.fault <= flt || tmo;
      if (flt || tmo) bus.fault_code <= tmo ? 2'b11 : aligned ? 2'b10 : 2'b01;
      ip[0] <= ptag == 4'b0100;
      dp[0] <= din;
      for (int i = 1; i < READ_LAT; i++) begin
        ip[i] <= ip[i-1];
        dp[i] <= dp[i-1];
      end
    end
  end
endmodule

// File: tb/tb_mem_access_router.sv
// tb_mem_access_router: directed vector table plus IO handshake, latency and reset sequences
module tb_mem_access_router;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int tests = 0;
  int fails = 0;
  logic [1:0] exp_code = 2'b00;
  typedef struct {
    logic [31:0] pc, addr;
    logic req, we;
    logic [1:0] size;
    logic [3:0] iwea, dwea;
    logic flt;
    logic [1:0] code;
  } vec_t;
  vec_t vec [14];
  mem_access_router_if #(.ADDR_W(32)) bus ();
  mem_access_router #(.ADDR_W(32), .READ_LAT(2), .IO_TIMEOUT(8), .IMEM_WR_NEEDS_BIOS(1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic idle;
    bus.mem_req = 1'b0;
    bus.mem_we = 1'b0;
    bus.mem_size = 2'b10;
    bus.data_addr = 32'h1000_0000;
  endtask
  task automatic access(input logic [31:0] addr, input logic we, input logic [1:0] size);
    bus.data_addr = addr;
    bus.mem_we = we;
    bus.mem_size = size;
    bus.mem_req = 1'b1;
  endtask
  initial begin
    vec[0]  = '{32'h1000_0000, 32'h1000_0010, 1'b1, 1'b1, 2'b10, 4'h0, 4'hf, 1'b0, 2'b00};
    vec[1]  = '{32'h4000_0000, 32'h3000_0006, 1'b1, 1'b1, 2'b01, 4'hc, 4'hc, 1'b0, 2'b00};
    vec[2]  = '{32'h1000_0000, 32'h3000_0006, 1'b1, 1'b1, 2'b01, 4'h0, 4'hc, 1'b0, 2'b00};
    vec[3]  = '{32'h1000_0000, 32'h1000_0003, 1'b1, 1'b1, 2'b00, 4'h0, 4'h8, 1'b0, 2'b00};
    vec[4]  = '{32'h1000_0000, 32'h1000_0002, 1'b1, 1'b1, 2'b10, 4'h0, 4'h0, 1'b1, 2'b01};
    vec[5]  = '{32'h4000_0000, 32'h2000_0002, 1'b1, 1'b1, 2'b01, 4'hc, 4'h0, 1'b0, 2'b00};
    vec[6]  = '{32'h4000_0000, 32'h4000_0000, 1'b1, 1'b1, 2'b10, 4'h0, 4'h0, 1'b0, 2'b00};
    vec[7]  = '{32'h1000_0000, 32'h5000_0001, 1'b1, 1'b1, 2'b00, 4'h0, 4'h0, 1'b1, 2'b10};
    vec[8]  = '{32'h1000_0000, 32'h1000_0000, 1'b1, 1'b1, 2'b11, 4'h0, 4'h0, 1'b1, 2'b01};
    vec[9]  = '{32'h1000_0000, 32'h1000_0000, 1'b1, 1'b0, 2'b10, 4'h0, 4'h0, 1'b0, 2'b00};
    vec[10] = '{32'h1000_0000, 32'h1000_0001, 1'b1, 1'b1, 2'b01, 4'h0, 4'h0, 1'b1, 2'b01};
    vec[11] = '{32'h1000_0000, 32'h7000_0000, 1'b0, 1'b1, 2'b10, 4'h0, 4'h0, 1'b0, 2'b00};
    vec[12] = '{32'h1000_0000, 32'h1000_0001, 1'b1, 1'b1, 2'b00, 4'h0, 4'h2, 1'b0, 2'b00};
    vec[13] = '{32'h1000_0000, 32'h6000_0000, 1'b1, 1'b0, 2'b00, 4'h0, 4'h0, 1'b1, 2'b10};
    bus.pc = 32'h1000_0000;
    bus.io_ack = 1'b0;
    idle();
    #1 rst_n = 1'b0;
    #1;
    chk("rst_iwea", bus.iwea, 0);
    chk("rst_dwea", bus.dwea, 0);
    chk("rst_io_req", bus.io_req, 0);
    chk("rst_io_we", bus.io_we, 0);
    chk("rst_io_be", bus.io_be, 0);
    chk("rst_stall", bus.stall, 0);
    chk("rst_fault", bus.fault, 0);
    chk("rst_fault_code", bus.fault_code, 0);
    chk("rst_iload_sel", bus.iload_sel, 0);
    chk("rst_dload_sel", bus.dload_sel, 0);
    #4 rst_n = 1'b1;
    tick;
    tick;
    for (int i = 0; i < 14; i++) begin
      bus.pc = vec[i].pc;
      bus.data_addr = vec[i].addr;
      bus.mem_req = vec[i].req;
      bus.mem_we = vec[i].we;
      bus.mem_size = vec[i].size;
      #1;
      chk($sformatf("v%0d_iwea", i), bus.iwea, vec[i].iwea);
      chk($sformatf("v%0d_dwea", i), bus.dwea, vec[i].dwea);
      chk($sformatf("v%0d_stall", i), bus.stall, 0);
      chk($sformatf("v%0d_fault_prev", i), bus.fault, 0);
      tick;
      idle();
      #1;
      if (vec[i].flt) exp_code = vec[i].code;
      chk($sformatf("v%0d_fault", i), bus.fault, vec[i].flt);
      chk($sformatf("v%0d_fault_code", i), bus.fault_code, exp_code);
      tick;
    end
    bus.pc = 32'h1000_0000;
    tick;
    tick;
    bus.pc = 32'h4000_0000;
    tick;
    bus.pc = 32'h1000_0000;
    chk("iload_lat1", bus.iload_sel, 0);
    tick;
    chk("iload_lat2", bus.iload_sel, 1);
    tick;
    chk("iload_after", bus.iload_sel, 0);
    access(32'h4000_0004, 1'b0, 2'b10);
    tick;
    idle();
    chk("dload_bios_lat1", bus.dload_sel, 2'b00);
    tick;
    chk("dload_bios_lat2", bus.dload_sel, 2'b01);
    tick;
    chk("dload_bios_after", bus.dload_sel, 2'b00);
    access(32'h8000_0000, 1'b0, 2'b10);
    #1;
    chk("ioload_req_stall", bus.stall, 1);
    chk("ioload_req_cycle_io_req", bus.io_req, 0);
    tick;
    idle();
    chk("ioload_io_we", bus.io_we, 0);
    chk("ioload_io_be", bus.io_be, 4'hf);
    for (int k = 1; k <= 5; k++) begin
      if (k == 5) bus.io_ack = 1'b1;
      #1;
      chk($sformatf("ioload_io_req_w%0d", k), bus.io_req, 1);
      chk($sformatf("ioload_stall_w%0d", k), bus.stall, k != 5);
      tick;
    end
    bus.io_ack = 1'b0;
    chk("ioload_io_req_done", bus.io_req, 0);
    chk("ioload_stall_done", bus.stall, 0);
    chk("ioload_dload_early", bus.dload_sel, 2'b00);
    tick;
    chk("ioload_dload", bus.dload_sel, 2'b10);
    chk("ioload_no_fault", bus.fault, 0);
    tick;
    chk("ioload_dload_after", bus.dload_sel, 2'b00);
    access(32'h8000_0004, 1'b1, 2'b01);
    #1;
    chk("iost_req_stall", bus.stall, 1);
    tick;
    idle();
    chk("iost_io_we", bus.io_we, 1);
    chk("iost_io_be", bus.io_be, 4'h3);
    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("iost_io_req_w%0d", k), bus.io_req, 1);
      chk($sformatf("iost_stall_w%0d", k), bus.stall, 1);
      tick;
    end
    exp_code = 2'b11;
    chk("tmo_io_req", bus.io_req, 0);
    chk("tmo_stall", bus.stall, 0);
    chk("tmo_fault", bus.fault, 1);
    chk("tmo_fault_code", bus.fault_code, exp_code);
    tick;
    chk("tmo_fault_pulse", bus.fault, 0);
    chk("tmo_fault_code_held", bus.fault_code, exp_code);
    bus.io_ack = 1'b1;
    #1;
    chk("stray_ack_stall", bus.stall, 0);
    tick;
    bus.io_ack = 1'b0;
    chk("stray_ack_io_req", bus.io_req, 0);
    chk("stray_ack_fault", bus.fault, 0);
    access(32'h8000_0008, 1'b1, 2'b10);
    tick;
    idle();
    for (int k = 1; k <= 7; k++) tick;
    chk("race_io_req", bus.io_req, 1);
    bus.io_ack = 1'b1;
    #1;
    chk("race_stall", bus.stall, 0);
    tick;
    bus.io_ack = 1'b0;
    chk("race_io_req_done", bus.io_req, 0);
    chk("race_no_fault", bus.fault, 0);
    chk("race_fault_code", bus.fault_code, exp_code);
    access(32'h8000_0000, 1'b0, 2'b10);
    tick;
    idle();
    tick;
    tick;
    chk("rstw_io_req_before", bus.io_req, 1);
    rst_n = 1'b0;
    #1;
    chk("rstw_io_req", bus.io_req, 0);
    chk("rstw_stall", bus.stall, 0);
    chk("rstw_fault_code", bus.fault_code, 0);
    #2 rst_n = 1'b1;
    tick;
    chk("rstw_io_req_after", bus.io_req, 0);
    chk("rstw_stall_after", bus.stall, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
